// File: rtl/imm_gen_pipe_if.sv
// rtl/imm_gen_pipe_if.sv - instruction-in / immediate-out handshake bundle for imm_gen_pipe
interface imm_gen_pipe_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_instr;
    logic [2:0]       in_fmt;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_imm;
    logic [TAG_W-1:0] out_tag;
    logic             out_err;

    modport master (
        output in_valid, in_instr, in_fmt, in_tag, out_ready,
        input  in_ready, out_valid, out_imm, out_tag, out_err
    );

    modport slave (
        input  in_valid, in_instr, in_fmt, in_tag, out_ready,
        output in_ready, out_valid, out_imm, out_tag, out_err
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - RV32/RV64 immediate extractor with registered output and 2-entry skid
module imm_gen_pipe #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    imm_gen_pipe_if.slave bus
);
    typedef struct packed {
        logic [XLEN-1:0]  imm;
        logic [TAG_W-1:0] tag;
        logic             err;
    } entry_t;

    function automatic logic [XLEN-1:0] extend(input logic [31:0] i, input logic [2:0] fmt);
        logic [XLEN-1:0] imm;
        imm = '0;
        case (fmt)
            3'd0: imm = XLEN'($signed(i[31:20]));
            3'd1: imm = XLEN'($signed({i[31:25], i[11:7]}));
            3'd2: imm = XLEN'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
            3'd3: imm = XLEN'($signed({i[31:12], 12'b0}));
            3'd4: imm = XLEN'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
            3'd5: imm = XLEN'(i[31:20]);
            3'd6: begin
                if (XLEN == 64) imm = XLEN'(i[25:20]);
                else            imm = XLEN'(i[24:20]);
            end
            default: imm = '0;
        endcase
        return imm;
    endfunction

    entry_t out_q, out_d, skid_q, skid_d, in_e;
    logic   out_valid_q, out_valid_d;
    logic   skid_valid_q, skid_valid_d;
    logic   in_ready_q, in_ready_d;
    logic   accept, drain;
    logic   unused_opcode;

    // Opcode bits never contribute to any immediate.
    assign unused_opcode = ^bus.in_instr[6:0];

    assign in_e.imm = extend(bus.in_instr, bus.in_fmt);
    assign in_e.tag = bus.in_tag;
    assign in_e.err = (bus.in_fmt == 3'd7);

    assign accept = bus.in_valid & in_ready_q;
    assign drain  = ~out_valid_q | bus.out_ready;

    always_comb begin
        out_d        = out_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        if (drain) begin
            if (skid_valid_q) begin
                out_d        = skid_q;
                out_valid_d  = 1'b1;
                skid_valid_d = accept;
                if (accept) skid_d = in_e;
            end else begin
                out_valid_d = accept;
                if (accept) out_d = in_e;
            end
        end else if (accept) begin
            skid_valid_d = 1'b1;
            skid_d       = in_e;
        end
        // Flush kills valids only; payload registers may keep stale data.
        if (flush) begin
            out_valid_d  = 1'b0;
            skid_valid_d = 1'b0;
        end
        in_ready_d = ~skid_valid_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q        <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b0;
        end else begin
            out_q        <= out_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_imm   = out_q.imm;
    assign bus.out_tag   = out_q.tag;
    assign bus.out_err   = out_q.err;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - scoreboard bench for imm_gen_pipe at XLEN 32 and 64
module tb_imm_gen_pipe;
    logic clk = 1'b0;
    logic rst;
    logic flush;
    always #5 clk = ~clk;

    imm_gen_pipe_if #(.XLEN(32), .TAG_W(5)) b32();
    imm_gen_pipe_if #(.XLEN(64), .TAG_W(5)) b64();

    assign b64.in_valid  = b32.in_valid;
    assign b64.in_instr  = b32.in_instr;
    assign b64.in_fmt    = b32.in_fmt;
    assign b64.in_tag    = b32.in_tag;
    assign b64.out_ready = b32.out_ready;

    imm_gen_pipe #(.XLEN(32), .TAG_W(5)) dut32 (.clk(clk), .rst(rst), .flush(flush), .bus(b32));
    imm_gen_pipe #(.XLEN(64), .TAG_W(5)) dut64 (.clk(clk), .rst(rst), .flush(flush), .bus(b64));

    typedef struct {
        logic [63:0] imm;
        logic [4:0]  tag;
        logic        err;
    } exp_t;

    exp_t q32[$];
    exp_t q64[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   pops     = 0;
    logic rnd_done;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Immediate value from the ISA field layout, expressed as signed arithmetic.
    function automatic logic [63:0] ref_imm(input logic [31:0] i, input logic [2:0] fmt, input int xlen);
        longint v;
        case (fmt)
            3'd0: v = longint'($signed(i[31:20]));
            3'd1: v = longint'($signed({i[31:25], i[11:7]}));
            3'd2: v = longint'($signed({i[31], i[7], i[30:25], i[11:8]})) * 64'sd2;
            3'd3: v = longint'($signed(i[31:12])) * 64'sd4096;
            3'd4: v = longint'($signed({i[31], i[19:12], i[20], i[30:21]})) * 64'sd2;
            3'd5: v = {52'b0, i[31:20]};
            3'd6: v = (xlen == 64) ? {58'b0, i[25:20]} : {59'b0, i[24:20]};
            default: v = 64'sd0;
        endcase
        if (xlen == 32) return {32'b0, v[31:0]};
        return v;
    endfunction

    // Monitor: pops the scoreboard on every output handshake, checks hold while stalled.
    logic        stall_prev = 1'b0;
    logic [38:0] prev32;
    logic [63:0] prev64;
    always @(negedge clk) begin
        if (!rst && !flush) begin
            if (stall_prev) begin
                chk("hold32", {25'b0, b32.out_valid, b32.out_imm, b32.out_tag, b32.out_err}, {25'b0, prev32});
                chk("hold64", b64.out_imm, prev64);
            end
            if (b32.out_valid && b32.out_ready) begin
                if (q32.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected32: got tag %0d expected no output", b32.out_tag);
                end else begin
                    exp_t e;
                    e = q32.pop_front();
                    chk("imm32", {32'b0, b32.out_imm}, e.imm);
                    chk("tag32", {59'b0, b32.out_tag}, {59'b0, e.tag});
                    chk("err32", {63'b0, b32.out_err}, {63'b0, e.err});
                    pops++;
                end
            end
            if (b64.out_valid && b64.out_ready) begin
                if (q64.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL unexpected64: got tag %0d expected no output", b64.out_tag);
                end else begin
                    exp_t e;
                    e = q64.pop_front();
                    chk("imm64", b64.out_imm, e.imm);
                    chk("tag64", {59'b0, b64.out_tag}, {59'b0, e.tag});
                    chk("err64", {63'b0, b64.out_err}, {63'b0, e.err});
                end
            end
            stall_prev = b32.out_valid && !b32.out_ready;
            prev32     = {b32.out_valid, b32.out_imm, b32.out_tag, b32.out_err};
            prev64     = b64.out_imm;
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic send(input logic [31:0] instr, input logic [2:0] fmt, input logic [4:0] tag,
                        output int waits);
        logic got;
        exp_t e;
        b32.in_valid = 1'b1;
        b32.in_instr = instr;
        b32.in_fmt   = fmt;
        b32.in_tag   = tag;
        waits = 0;
        got   = 1'b0;
        while (1) begin
            got = b32.in_ready;
            @(posedge clk); #1;
            if (got) break;
            waits++;
            if (waits > 500) begin
                n_checks++; n_fail++;
                $display("FAIL send_timeout: tag %0d not accepted in %0d cycles", tag, waits);
                break;
            end
        end
        if (got) begin
            e.tag = tag;
            e.err = (fmt == 3'd7);
            e.imm = ref_imm(instr, fmt, 32);
            q32.push_back(e);
            e.imm = ref_imm(instr, fmt, 64);
            q64.push_back(e);
        end
    endtask

    task automatic idle(input int n);
        b32.in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #1_000_000;
        n_checks++; n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        int w;
        int p0;
        rst = 1'b1; flush = 1'b0; rnd_done = 1'b0;
        b32.in_valid = 1'b0; b32.in_instr = '0; b32.in_fmt = '0; b32.in_tag = '0;
        b32.out_ready = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {63'b0, b32.out_valid}, 64'd0);
        chk("rst_in_ready", {63'b0, b32.in_ready}, 64'd0);
        chk("rst_imm", {32'b0, b32.out_imm}, 64'd0);
        chk("rst_tag_err", {58'b0, b32.out_tag, b32.out_err}, 64'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rst_release_in_ready", {63'b0, b32.in_ready}, 64'd1);

        // Directed extension vectors, one cycle after acceptance.
        b32.out_ready = 1'b1;
        send(32'hFFF0_0093, 3'd0, 5'd1, w);
        chk("t1_valid", {63'b0, b32.out_valid}, 64'd1);
        chk("t1_imm", {32'b0, b32.out_imm}, 64'h0000_0000_FFFF_FFFF);
        send(32'hFE00_0EE3, 3'd2, 5'd2, w);
        chk("t2_b_minus4", {32'b0, b32.out_imm}, 64'h0000_0000_FFFF_FFFC);
        send(32'hFE00_0E63, 3'd2, 5'd3, w);
        chk("t2_b_minus2052", {32'b0, b32.out_imm}, 64'h0000_0000_FFFF_F7FC);
        send(32'h8000_00B7, 3'd3, 5'd4, w);
        chk("t2_u64", b64.out_imm, 64'hFFFF_FFFF_8000_0000);
        send(32'h1234_5678, 3'd7, 5'd5, w);
        chk("t5_err", {63'b0, b32.out_err}, 64'd1);
        chk("t5_err_imm", {32'b0, b32.out_imm}, 64'd0);
        send(32'h8000_0013, 3'd5, 5'd6, w);
        chk("t5_iu", {32'b0, b32.out_imm}, 64'h0000_0000_0000_0800);
        send(32'h03F0_0013, 3'd6, 5'd7, w);
        chk("shamt32", {32'b0, b32.out_imm}, 64'd31);
        chk("shamt64", b64.out_imm, 64'd63);
        idle(2);

        // Back-pressure: third input stalls until the consumer releases.
        b32.out_ready = 1'b0;
        p0 = pops;
        send(32'h0010_0093, 3'd0, 5'd1, w);
        send(32'h0020_0093, 3'd0, 5'd2, w);
        chk("t3_full_in_ready", {63'b0, b32.in_ready}, 64'd0);
        fork
            send(32'h0030_0093, 3'd0, 5'd3, w);
            begin
                repeat (3) @(posedge clk);
                #2;
                chk("t3_stall_in_ready", {63'b0, b32.in_ready}, 64'd0);
                b32.out_ready = 1'b1;
            end
        join
        idle(4);
        chk("t3_pops", 64'(pops - p0), 64'd3);

        // Streaming at full rate.
        p0 = pops;
        for (int k = 0; k < 8; k++) begin
            send($urandom, 3'(k % 7), 5'(8 + k), w);
            chk("t4_no_wait", 64'(w), 64'd0);
        end
        b32.in_valid = 1'b0;
        @(negedge clk); #1;
        chk("t4_pops", 64'(pops - p0), 64'd8);
        idle(2);

        // Flush with both entries full and a new input presented.
        b32.out_ready = 1'b0;
        send(32'h00A0_0093, 3'd0, 5'd10, w);
        send(32'h00B0_0093, 3'd0, 5'd11, w);
        flush = 1'b1;
        b32.in_valid = 1'b1; b32.in_instr = 32'h00C0_0093; b32.in_fmt = 3'd0; b32.in_tag = 5'd12;
        @(posedge clk); #1;
        flush = 1'b0;
        b32.in_valid = 1'b0;
        q32.delete();
        q64.delete();
        chk("t6_out_valid", {63'b0, b32.out_valid}, 64'd0);
        chk("t6_in_ready", {63'b0, b32.in_ready}, 64'd1);
        b32.out_ready = 1'b1;
        idle(5);
        chk("t6_still_empty", {63'b0, b32.out_valid}, 64'd0);

        // Random traffic under random back-pressure.
        fork
            begin
                for (int k = 0; k < 300; k++) begin
                    send($urandom, 3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), w);
                    if ($urandom_range(0, 3) == 0) idle(1);
                end
                b32.in_valid = 1'b0;
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #2;
                    b32.out_ready = ($urandom_range(0, 2) != 0);
                end
            end
        join

        b32.out_ready = 1'b1;
        for (int k = 0; k < 50 && q32.size() != 0; k++) @(posedge clk);
        @(negedge clk); #1;
        chk("drain32", 64'(q32.size()), 64'd0);
        chk("drain64", 64'(q64.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
